mem_region_cmp: RTL and testbench
=================================

# mem_region_cmp

Synthesizable memory-region comparator that sits beside the scalar core on a read-only port into the shared memory. It reads two equal-length word regions through a req/ready interface and compares them word by word. It reports the mismatch count and the first mismatching offset, replacing the bench-only region comparison with a parametrised hardware engine. An optional tolerance mode compares numerically instead of bitwise, for fixed-point MLP outputs.

## Interface
- DWidth, 32, data word width in bits (multiple of 8)
- AWidth, 32, byte-address width
- CntWidth, 24, width of size and count fields
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  start request, sampled in IDLE only
- addr1_i  in  AWidth  byte base of region A
- addr2_i  in  AWidth  byte base of region B
- size_i  in  CntWidth  region length in bytes
- tol_i  in  DWidth  unsigned tolerance (tolerance mode only)
- busy_o  out  1  engine walking regions
- done_o  out  1  one-cycle completion pulse
- mis_cnt_o  out  CntWidth  mismatching word count, saturating
- first_vld_o  out  1  at least one mismatch found
- first_off_o  out  CntWidth  byte offset of first mismatch
- mem_req_o  out  1  read request
- mem_addr_o  out  AWidth  read byte address
- mem_ready_i  in  1  read accepted, data valid this cycle
- mem_rdata_i  in  DWidth  read data

## Operation
- Word count N = size_i / (DWidth/8); the remainder is ignored. Base addresses are word-aligned by forcing the low log2(DWidth/8) bits to 0.
- FSM states: IDLE, RD_A, RD_B, CMP, DONE.
- IDLE: when start_i=1, latch the inputs and clear mis_cnt_o, first_vld_o and first_off_o. If N=0, go to DONE; otherwise go to RD_A.
- RD_A: mem_req_o=1 and mem_addr_o=baseA+idx*WB. When mem_ready_i=1, capture rdata into regA and go to RD_B.
- RD_B: mem_req_o=1 and mem_addr_o=baseB+idx*WB. When mem_ready_i=1, capture into regB and go to CMP.
- CMP: evaluate mismatch. On a mismatch, increment mis_cnt_o (hold at all-ones) and, if first_vld_o=0, set first_vld_o=1 and first_off_o=idx*WB. Increment idx. Go to DONE if idx was N-1, else go to RD_A.
- DONE: done_o=1 for exactly this cycle, then go to IDLE.
- Handshake: the address is held stable while mem_req_o=1 and mem_ready_i=0, with no timeout.
- Address arithmetic is modulo 2^AWidth, so a region may wrap past the top of the address space.
- start_i is ignored outside IDLE. Results hold from DONE until the next accepted start.
- mem_ready_i is ignored when mem_req_o=0.

## Timing
- Reset values, asserted on the rst_ni edge including mid-operation: state IDLE; mem_req_o=0, mem_addr_o=0, busy_o=0, done_o=0, mis_cnt_o=0, first_vld_o=0, first_off_o=0.
- busy_o=1 in RD_A, RD_B and CMP.
- All outputs are registered or state-decoded, with no combinational path from input to output.
- Zero-wait latency: if start is sampled at edge 0, done_o is high in cycle 3N+1 (3 cycles per word).
- Each stall cycle (mem_ready_i=0 with req=1) adds one cycle.
- With N=0, done_o is high in cycle 1 and no request is issued.

## Configuration
- MEM_CMP_TOLERANCE_EN defined: a word mismatches when |signed(regA) − signed(regB)| > tol_i. The difference is computed at DWidth+1 bits so there is no overflow.
- Undefined: a word mismatches when regA != regB. tol_i is present but ignored.

## Structure
- Package pkg_mem_cmp holds the state enum typedef (IDLE, RD_A, RD_B, CMP, DONE) and the WordBytes constant.
- Sub-module mem_cmp_unit: combinational compare of regA and regB. It holds the macro-selected exact or tolerance logic and outputs a single mismatch bit.

## Test plan
- Identical regions with N=16 and mem_ready_i=1 throughout → done_o in cycle 49, mis_cnt_o=0, first_vld_o=0.
- Regions differing at word offsets 0x14 and 0x3C → mis_cnt_o=2, first_off_o=0x14, first_vld_o=1.
- Random mem_ready_i stalls, 50% duty → same results as zero-wait; mem_addr_o is stable through every stall.
- Tolerance build with A=100, B=103: tol_i=3 → no mismatch; tol_i=2 → mis_cnt_o=1. With A=0x7FFFFFFF, B=0x80000000 and tol=5 → mismatch.
- size_i=0 → done_o in cycle 1 with no mem_req_o. size_i=6 → exactly one word compared. Region A at 0xFFFFFFFC with N=2 → second read at 0x00000000.
- rst_ni low during RD_B → next cycle IDLE, mem_req_o=0, counters 0. start_i pulsed while busy → ignored; the run finishes normally.

Source files
------------

// File: rtl/pkg_mem_cmp.sv
// Shared types and constants for the memory-region comparator.
package pkg_mem_cmp;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StCmp,
    StDone
  } state_e;

  // Bytes per word at the default 32-bit data width.
  localparam int unsigned WordBytes = 4;

  function automatic int unsigned word_bytes(int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/mem_cmp_unit.sv
// Combinational word compare. Bitwise by default; numeric |A-B| > tol when
// MEM_CMP_TOLERANCE_EN is defined.
module mem_cmp_unit #(
  parameter int unsigned DWidth = 32
) (
  input  logic [DWidth-1:0] a_i,
  input  logic [DWidth-1:0] b_i,
  input  logic [DWidth-1:0] tol_i,
  output logic              mismatch_o
);

`ifdef MEM_CMP_TOLERANCE_EN
  logic [DWidth:0] diff;
  logic [DWidth:0] mag;

  // Sign-extend by one bit so the difference of two signed words cannot overflow.
  always_comb begin
    diff       = {a_i[DWidth-1], a_i} - {b_i[DWidth-1], b_i};
    mag        = diff[DWidth] ? (~diff + 1'b1) : diff;
    mismatch_o = (mag > {1'b0, tol_i});
  end
`else
  logic unused_tol;
  assign unused_tol = ^tol_i;
  assign mismatch_o = (a_i != b_i);
`endif

endmodule

// File: rtl/mem_region_cmp.sv
// Memory-region comparator: walks two word regions over a req/ready read port and
// reports mismatch count and first mismatching offset. Optional MEM_CMP_TOLERANCE_EN.
module mem_region_cmp
  import pkg_mem_cmp::*;
#(
  parameter int unsigned DWidth   = 8 * WordBytes,
  parameter int unsigned AWidth   = 32,
  parameter int unsigned CntWidth = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [AWidth-1:0]   addr1_i,
  input  logic [AWidth-1:0]   addr2_i,
  input  logic [CntWidth-1:0] size_i,
  input  logic [DWidth-1:0]   tol_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CntWidth-1:0] mis_cnt_o,
  output logic                first_vld_o,
  output logic [CntWidth-1:0] first_off_o,
  output logic                mem_req_o,
  output logic [AWidth-1:0]   mem_addr_o,
  input  logic                mem_ready_i,
  input  logic [DWidth-1:0]   mem_rdata_i
);

  localparam int unsigned Wb      = word_bytes(DWidth);
  localparam int unsigned WbShift = $clog2(Wb);
  localparam logic [AWidth-1:0] AlignMask = {AWidth{1'b1}} << WbShift;

  state_e              state_q, state_d;
  logic [AWidth-1:0]   base_a_q, base_a_d;
  logic [AWidth-1:0]   base_b_q, base_b_d;
  logic [CntWidth-1:0] n_q, n_d;
  logic [CntWidth-1:0] idx_q, idx_d;
  logic [DWidth-1:0]   reg_a_q, reg_a_d;
  logic [DWidth-1:0]   reg_b_q, reg_b_d;
  logic [DWidth-1:0]   tol_q, tol_d;
  logic [CntWidth-1:0] mis_cnt_q, mis_cnt_d;
  logic                first_vld_q, first_vld_d;
  logic [CntWidth-1:0] first_off_q, first_off_d;

  logic [CntWidth-1:0] size_words;
  logic [CntWidth-1:0] off;
  logic                mismatch;

  assign size_words = size_i >> WbShift;
  assign off        = idx_q << WbShift;

  mem_cmp_unit #(
    .DWidth(DWidth)
  ) u_cmp (
    .a_i       (reg_a_q),
    .b_i       (reg_b_q),
    .tol_i     (tol_q),
    .mismatch_o(mismatch)
  );

  always_comb begin
    state_d     = state_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    n_d         = n_q;
    idx_d       = idx_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    tol_d       = tol_q;
    mis_cnt_d   = mis_cnt_q;
    first_vld_d = first_vld_q;
    first_off_d = first_off_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_a_d    = addr1_i & AlignMask;
          base_b_d    = addr2_i & AlignMask;
          n_d         = size_words;
          idx_d       = '0;
          tol_d       = tol_i;
          mis_cnt_d   = '0;
          first_vld_d = 1'b0;
          first_off_d = '0;
          state_d     = (size_words == '0) ? StDone : StRdA;
        end
      end
      StRdA: begin
        if (mem_ready_i) begin
          reg_a_d = mem_rdata_i;
          state_d = StRdB;
        end
      end
      StRdB: begin
        if (mem_ready_i) begin
          reg_b_d = mem_rdata_i;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (mismatch) begin
          if (mis_cnt_q != '1) begin
            mis_cnt_d = mis_cnt_q + 1'b1;
          end
          if (!first_vld_q) begin
            first_vld_d = 1'b1;
            first_off_d = off;
          end
        end
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == n_q - 1'b1) ? StDone : StRdA;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_a_q    <= '0;
      base_b_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      tol_q       <= '0;
      mis_cnt_q   <= '0;
      first_vld_q <= 1'b0;
      first_off_q <= '0;
    end else begin
      state_q     <= state_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      tol_q       <= tol_d;
      mis_cnt_q   <= mis_cnt_d;
      first_vld_q <= first_vld_d;
      first_off_q <= first_off_d;
    end
  end

  // Outputs decode state and registers only; the address wraps modulo 2^AWidth.
  always_comb begin
    busy_o     = (state_q == StRdA) || (state_q == StRdB) || (state_q == StCmp);
    done_o     = (state_q == StDone);
    mem_req_o  = (state_q == StRdA) || (state_q == StRdB);
    mem_addr_o = '0;
    if (state_q == StRdA) begin
      mem_addr_o = base_a_q + AWidth'(off);
    end else if (state_q == StRdB) begin
      mem_addr_o = base_b_q + AWidth'(off);
    end
  end

  assign mis_cnt_o   = mis_cnt_q;
  assign first_vld_o = first_vld_q;
  assign first_off_o = first_off_q;

endmodule

// File: tb/tb_mem_region_cmp.sv
// Self-checking bench for mem_region_cmp: vector table, random runs against a
// word-level reference model, and hand-written reset / busy-start sequences.
module tb_mem_region_cmp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr1 = '0;
  logic [31:0] addr2 = '0;
  logic [23:0] size = '0;
  logic [31:0] tol = '0;
  logic        busy, done, first_vld, mem_req;
  logic        mem_ready = 1'b0;
  logic [23:0] mis_cnt, first_off;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_region_cmp #(
    .DWidth  (32),
    .AWidth  (32),
    .CntWidth(24)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .addr1_i    (addr1),
    .addr2_i    (addr2),
    .size_i     (size),
    .tol_i      (tol),
    .busy_o     (busy),
    .done_o     (done),
    .mis_cnt_o  (mis_cnt),
    .first_vld_o(first_vld),
    .first_off_o(first_off),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_ready_i(mem_ready),
    .mem_rdata_i(mem_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [logic [31:0]];
  bit          stall_en = 1'b0;
  int          stalls = 0;
  logic [31:0] acc_q [$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
  endfunction

  function automatic bit word_mis(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] t);
`ifdef MEM_CMP_TOLERANCE_EN
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d < 0) d = -d;
    return d > longint'(t);
`else
    return a != b;
`endif
  endfunction

  // Memory responder: ready/data driven on negedge, accepted addresses logged.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      mem_ready  = 1'b0;
    end else begin
      if (prev_stall) check("addr_hold", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, prev_addr});
      mem_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rdata = mem_rd(mem_addr);
      if (mem_req && mem_ready) acc_q.push_back(mem_addr);
      if (mem_req && !mem_ready) stalls++;
      prev_stall = mem_req && !mem_ready;
      prev_addr  = mem_addr;
    end
  end

  task automatic run(input string tag, input logic [31:0] a1, input logic [31:0] a2,
                     input logic [23:0] sz, input logic [31:0] t, input bit stall,
                     input bit pulse_busy);
    int          n, emis, cyc;
    bit          evld, ok;
    logic [23:0] eoff;
    logic [31:0] ba, bb, pa, pb;
    logic [31:0] exp_q [$];
    n = int'(sz) / 4;
    ba = a1 & ~32'h3;
    bb = a2 & ~32'h3;
    emis = 0;
    evld = 1'b0;
    eoff = '0;
    for (int i = 0; i < n; i++) begin
      pa = ba + 32'(i * 4);
      pb = bb + 32'(i * 4);
      exp_q.push_back(pa);
      exp_q.push_back(pb);
      if (word_mis(mem_rd(pa), mem_rd(pb), t)) begin
        if (!evld) begin
          evld = 1'b1;
          eoff = 24'(i * 4);
        end
        emis++;
      end
    end
    stall_en = stall;
    @(negedge clk);
    start = 1'b1; addr1 = a1; addr2 = a2; size = sz; tol = t;
    acc_q.delete();
    stalls = 0;
    @(negedge clk);
    start = 1'b0; addr1 = $urandom; addr2 = $urandom; size = 24'($urandom); tol = $urandom;
    cyc = 1;
    if (n > 0) check({tag, " busy"}, {63'b0, busy}, 64'd1);
    while (!done && cyc < 5000) begin
      if (pulse_busy && cyc == 2) start = 1'b1;
      if (cyc == 3) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 64'(cyc), 64'(3 * n + 1 + stalls));
    check({tag, " mis_cnt"}, {40'b0, mis_cnt}, 64'(emis));
    check({tag, " first_vld"}, {63'b0, first_vld}, {63'b0, evld});
    check({tag, " first_off"}, {40'b0, first_off}, {40'b0, eoff});
    ok = (acc_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (acc_q[i] !== exp_q[i]) ok = 1'b0;
    check({tag, " addr_seq"}, {63'b0, ok}, 64'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, {62'b0, done, busy}, 64'd0);
    check({tag, " result_hold"}, {40'b0, mis_cnt}, 64'(emis));
  endtask

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [23:0] sz;
    bit          stall;
    bit          pulse;
    int          d0;
    int          d1;
    int          exp_mis;
    bit          exp_vld;
    logic [23:0] exp_off;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] ba, bb, v;
    int          nw;

    vecs[0] = '{32'h1000, 32'h2000, 24'd64, 1'b0, 1'b0, -1, -1, 0, 1'b0, 24'h0};
    vecs[1] = '{32'h1000, 32'h2000, 24'd64, 1'b0, 1'b0, 'h14, 'h3C, 2, 1'b1, 24'h14};
    vecs[2] = '{32'h1000, 32'h2000, 24'd64, 1'b1, 1'b0, 'h14, 'h3C, 2, 1'b1, 24'h14};
    vecs[3] = '{32'h1000, 32'h2000, 24'd0, 1'b0, 1'b0, 0, -1, 0, 1'b0, 24'h0};
    vecs[4] = '{32'h1000, 32'h2000, 24'd6, 1'b0, 1'b0, 0, 4, 1, 1'b1, 24'h0};
    vecs[5] = '{32'hFFFF_FFFC, 32'h3000, 24'd8, 1'b0, 1'b0, 4, -1, 1, 1'b1, 24'h4};
    vecs[6] = '{32'h1003, 32'h2001, 24'd19, 1'b1, 1'b0, 12, -1, 1, 1'b1, 24'hC};
    vecs[7] = '{32'h400, 32'h800, 24'd20, 1'b0, 1'b1, 8, 16, 2, 1'b1, 24'h8};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {59'b0, busy, done, mem_req, first_vld, 1'b0}, 64'd0);
    check("rst_addr", {32'b0, mem_addr}, 64'd0);
    check("rst_cnt", {16'b0, mis_cnt, first_off}, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      mem.delete();
      ba = vecs[k].a1 & ~32'h3;
      bb = vecs[k].a2 & ~32'h3;
      nw = int'(vecs[k].sz) / 4 + 2;
      for (int i = 0; i < nw; i++) begin
        v = $urandom;
        mem[ba + 32'(i * 4)] = v;
        mem[bb + 32'(i * 4)] = v;
      end
      if (vecs[k].d0 >= 0) mem[bb + 32'(vecs[k].d0)] = mem[ba + 32'(vecs[k].d0)] ^ 32'h1;
      if (vecs[k].d1 >= 0) mem[bb + 32'(vecs[k].d1)] = mem[ba + 32'(vecs[k].d1)] ^ 32'h1;
      run($sformatf("vec%0d", k), vecs[k].a1, vecs[k].a2, vecs[k].sz, 32'h0,
          vecs[k].stall, vecs[k].pulse);
      check($sformatf("vec%0d tbl_mis", k), {40'b0, mis_cnt}, 64'(vecs[k].exp_mis));
      check($sformatf("vec%0d tbl_vld", k), {63'b0, first_vld}, {63'b0, vecs[k].exp_vld});
      check($sformatf("vec%0d tbl_off", k), {40'b0, first_off}, {40'b0, vecs[k].exp_off});
    end

    for (int r = 0; r < 20; r++) begin
      logic [31:0] ra1, ra2;
      logic [23:0] rsz;
      mem.delete();
      ra1 = $urandom;
      ra2 = $urandom;
      rsz = 24'($urandom_range(0, 120));
      ba = ra1 & ~32'h3;
      bb = ra2 & ~32'h3;
      for (int i = 0; i < int'(rsz) / 4; i++) begin
        v = $urandom;
        mem[ba + 32'(i * 4)] = v;
        case ($urandom_range(0, 3))
          0: mem[bb + 32'(i * 4)] = $urandom;
          1: mem[bb + 32'(i * 4)] = v + 32'($urandom_range(0, 16)) - 32'd8;
          default: mem[bb + 32'(i * 4)] = v;
        endcase
      end
      run($sformatf("rnd%0d", r), ra1, ra2, rsz, 32'($urandom_range(0, 8)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef MEM_CMP_TOLERANCE_EN
    mem.delete();
    mem[32'h100] = 32'd100;
    mem[32'h200] = 32'd103;
    run("tol3", 32'h100, 32'h200, 24'd4, 32'd3, 1'b0, 1'b0);
    check("tol3 none", {40'b0, mis_cnt}, 64'd0);
    run("tol2", 32'h100, 32'h200, 24'd4, 32'd2, 1'b0, 1'b0);
    check("tol2 one", {40'b0, mis_cnt}, 64'd1);
    mem[32'h100] = 32'h7FFF_FFFF;
    mem[32'h200] = 32'h8000_0000;
    run("tol_ext", 32'h100, 32'h200, 24'd4, 32'd5, 1'b0, 1'b0);
    check("tol_ext one", {40'b0, mis_cnt}, 64'd1);
`endif

    // Reset while reading region B.
    mem.delete();
    stall_en = 1'b0;
    @(negedge clk);
    start = 1'b1; addr1 = 32'h100; addr2 = 32'h200; size = 24'd16;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstb in_rdb", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h200});
    rst_n = 1'b0;
    @(negedge clk);
    check("rstb ctrl", {59'b0, busy, done, mem_req, first_vld, 1'b0}, 64'd0);
    check("rstb addr", {32'b0, mem_addr}, 64'd0);
    check("rstb cnt", {16'b0, mis_cnt, first_off}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstb idle", {62'b0, busy, mem_req}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
